write_back_stage: RTL and testbench

Parametrised write-back stage with its own MEM/WB holding register. It selects the destination-register value from four sources: ALU result, formatted load data, PC+step (JAL/JALR link) and U-immediate (LUI). It adds load byte/half/word extraction with sign/zero extension, support for a data-memory response that arrives late, flush, and a retire counter. Its output drives the register-file write port and the forwarding path to execute.

---
 rtl/write_back_stage.sv | 148 ++++++++++++++
 tb/tb_write_back_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// MEM/WB write-back: selects ALU / formatted load / PC+step / U-imm into rd, counts retired ops.
// Latency 1 edge after accept (or after late load data); in_ready drops only while waiting on load data.
module write_back_stage #(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4,
    parameter int AW      = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_wb_sel,
    input  logic            in_rd_en,
    input  logic [4:0]      in_rd_addr,
    input  logic [XLEN-1:0] in_alu_out,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_u_imm,
    input  logic [2:0]      in_ld_funct3,
    input  logic [AW-1:0]   in_ld_addr_lo,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            load_err,
    output logic            busy,
    output logic [63:0]     instret
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC   = 2'b10;

    state_t          state;
    logic            p_rd_en;
    logic [4:0]      p_rd_addr;
    logic [2:0]      p_funct3;
    logic [AW-1:0]   p_addr_lo;

    logic            accept;
    logic            c_fire;
    logic            c_is_load;
    logic            c_en;
    logic [4:0]      c_addr;
    logic [2:0]      c_f3;
    logic [AW-1:0]   c_lo;
    logic [XLEN-1:0] c_data;
    logic            c_err;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] ld_val;
    logic            ld_err;
    logic [XLEN-1:0] nl_val;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT);
    assign accept   = in_valid & in_ready & ~flush;

    // In WAIT the commit comes from the held load fields, otherwise straight from the inputs.
    always_comb begin
        c_is_load = 1'b1;
        c_en      = p_rd_en;
        c_addr    = p_rd_addr;
        c_f3      = p_funct3;
        c_lo      = p_addr_lo;
        c_fire    = 1'b0;
        if (state == IDLE) begin
            c_is_load = (in_wb_sel == SEL_LOAD);
            c_en      = in_rd_en;
            c_addr    = in_rd_addr;
            c_f3      = in_ld_funct3;
            c_lo      = in_ld_addr_lo;
            c_fire    = accept & (~c_is_load | mem_rsp_valid);
        end else begin
            c_fire    = ~flush & mem_rsp_valid;
        end
    end

    always_comb begin
        sh     = mem_rsp_data >> {c_lo, 3'b000};
        ld_val = sh;
        ld_err = 1'b0;
        case (c_f3)
            3'b000: ld_val = XLEN'($signed(sh[7:0]));
            3'b100: ld_val = XLEN'(sh[7:0]);
            3'b001: begin ld_val = XLEN'($signed(sh[15:0])); ld_err = c_lo[0]; end
            3'b101: begin ld_val = XLEN'(sh[15:0]);          ld_err = c_lo[0]; end
            3'b010: begin ld_val = XLEN'($signed(sh[31:0])); ld_err = (c_lo[1:0] != 2'b00); end
            3'b110: begin
                ld_val = XLEN'(sh[31:0]);
                ld_err = (XLEN != 64) || (c_lo[1:0] != 2'b00);
            end
            3'b011: ld_err = (XLEN != 64) || (c_lo != '0);
            default: ld_err = 1'b1;
        endcase
    end

    always_comb begin
        case (in_wb_sel)
            SEL_ALU: nl_val = in_alu_out;
            SEL_PC:  nl_val = in_pc + XLEN'(PC_STEP);
            default: nl_val = in_u_imm;
        endcase
        c_data = c_is_load ? ld_val : nl_val;
        c_err  = c_is_load & ld_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_we     <= 1'b0;
            rd_addr   <= 5'd0;
            rd_wdata  <= '0;
            load_err  <= 1'b0;
            instret   <= 64'd0;
            p_rd_en   <= 1'b0;
            p_rd_addr <= 5'd0;
            p_funct3  <= 3'd0;
            p_addr_lo <= '0;
        end else begin
            rd_we    <= 1'b0;
            load_err <= 1'b0;
            if (accept) begin
                p_rd_en   <= in_rd_en;
                p_rd_addr <= in_rd_addr;
                p_funct3  <= in_ld_funct3;
                p_addr_lo <= in_ld_addr_lo;
                if (in_wb_sel == SEL_LOAD && !mem_rsp_valid)
                    state <= WAIT;
            end
            if (state == WAIT && (flush || mem_rsp_valid))
                state <= IDLE;
            if (c_fire) begin
                load_err <= c_err;
                if (!c_err) begin
                    instret <= instret + 64'd1;
                    // Address/data only move on a real write so they hold otherwise.
                    if (c_en && c_addr != 5'd0) begin
                        rd_we    <= 1'b1;
                        rd_addr  <= c_addr;
                        rd_wdata <= c_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_write_back_stage.sv
// Directed-vector bench for write_back_stage at XLEN=32.
module tb_write_back_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [1:0]  in_wb_sel;
    logic        in_rd_en;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_alu_out, in_pc, in_u_imm;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_ld_addr_lo;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        load_err, busy;
    logic [63:0] instret;

    int vecs = 0;
    int errs = 0;

    write_back_stage #(.XLEN(32), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_sel(in_wb_sel), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
        .in_alu_out(in_alu_out), .in_pc(in_pc), .in_u_imm(in_u_imm),
        .in_ld_funct3(in_ld_funct3), .in_ld_addr_lo(in_ld_addr_lo),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .load_err(load_err), .busy(busy), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] v,
                      input logic [2:0] f3, input logic [1:0] lo);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd_en      = 1'b1;
        in_rd_addr    = rd;
        in_alu_out    = v;
        in_pc         = v;
        in_u_imm      = v;
        in_ld_funct3  = f3;
        in_ld_addr_lo = lo;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_wb_sel = 2'b00; in_rd_en = 1'b0;
        in_rd_addr = 5'd0; in_alu_out = '0; in_pc = '0; in_u_imm = '0;
        in_ld_funct3 = 3'd0; in_ld_addr_lo = 2'd0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_we", rd_we, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_wdata", rd_wdata, 0);
        check("rst_err", load_err, 0);
        check("rst_instret", instret, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);

        // single ALU op
        op(2'b00, 5'd5, 32'h1234_5678, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        check("alu_we", rd_we, 1);
        check("alu_addr", rd_addr, 5);
        check("alu_wdata", rd_wdata, 32'h1234_5678);
        check("alu_instret", instret, 1);
        tick();
        check("alu_we_clr", rd_we, 0);
        check("alu_hold", rd_wdata, 32'h1234_5678);

        // four back-to-back ops
        for (int i = 0; i < 4; i++) begin
            op(2'b00, 5'(6 + i), 32'(100 + i), 3'd0, 2'd0);
            tick();
            check("b2b_we", rd_we, 1);
            check("b2b_addr", rd_addr, 64'(6 + i));
            check("b2b_wdata", rd_wdata, 64'(100 + i));
        end
        in_valid = 1'b0;
        check("b2b_instret", instret, 5);

        // loads with data in the accept cycle
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h80AA_BBCC;
        op(2'b01, 5'd7, 32'h0, 3'b000, 2'd3);
        tick();
        check("lb_wdata", rd_wdata, 32'hFFFF_FF80);
        check("lb_we", rd_we, 1);
        op(2'b01, 5'd7, 32'h0, 3'b100, 2'd3);
        tick();
        check("lbu_wdata", rd_wdata, 32'h0000_0080);
        op(2'b01, 5'd7, 32'h0, 3'b101, 2'd2);
        tick();
        check("lhu_wdata", rd_wdata, 32'h0000_80AA);
        op(2'b01, 5'd8, 32'h0, 3'b001, 2'd0);
        tick();
        check("lh_wdata", rd_wdata, 32'hFFFF_BBCC);
        op(2'b01, 5'd8, 32'h0, 3'b010, 2'd0);
        tick();
        check("lw_wdata", rd_wdata, 32'h80AA_BBCC);
        check("ld_instret", instret, 10);
        in_valid = 1'b0;
        mem_rsp_valid = 1'b0;

        // late load, response three cycles later
        op(2'b01, 5'd9, 32'h0, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        check("late_busy1", busy, 1);
        check("late_ready1", in_ready, 0);
        check("late_we1", rd_we, 0);
        tick();
        check("late_busy2", busy, 1);
        tick();
        check("late_busy3", busy, 1);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        op(2'b00, 5'd10, 32'h55, 3'd0, 2'd0);
        tick();
        mem_rsp_valid = 1'b0;
        check("late_we", rd_we, 1);
        check("late_addr", rd_addr, 9);
        check("late_wdata", rd_wdata, 32'hDEAD_BEEF);
        check("late_ready", in_ready, 1);
        check("late_busy0", busy, 0);
        tick();
        in_valid = 1'b0;
        check("next_we", rd_we, 1);
        check("next_addr", rd_addr, 10);
        check("next_wdata", rd_wdata, 32'h55);
        check("late_instret", instret, 12);

        // link wraps, LUI passes, rd=0 retires without writing
        op(2'b10, 5'd11, 32'hFFFF_FFFC, 3'd0, 2'd0);
        tick();
        check("jal_wdata", rd_wdata, 32'h0);
        check("jal_we", rd_we, 1);
        op(2'b11, 5'd12, 32'hABCD_E000, 3'd0, 2'd0);
        tick();
        check("lui_wdata", rd_wdata, 32'hABCD_E000);
        op(2'b00, 5'd0, 32'h77, 3'd0, 2'd0);
        tick();
        in_valid = 1'b0;
        check("x0_we", rd_we, 0);
        check("x0_instret", instret, 15);
        check("x0_hold_addr", rd_addr, 12);
        check("x0_hold_data", rd_wdata, 32'hABCD_E000);

        // misaligned and illegal loads
        mem_rsp_valid = 1'b1;
        op(2'b01, 5'd13, 32'h0, 3'b001, 2'd1);
        tick();
        check("lh_mis_err", load_err, 1);
        check("lh_mis_we", rd_we, 0);
        check("lh_mis_instret", instret, 15);
        op(2'b01, 5'd13, 32'h0, 3'b011, 2'd0);
        tick();
        in_valid = 1'b0;
        mem_rsp_valid = 1'b0;
        check("ld32_err", load_err, 1);
        check("ld32_instret", instret, 15);
        tick();
        check("err_clr", load_err, 0);

        // flush in IDLE blocks accept
        op(2'b00, 5'd14, 32'h99, 3'd0, 2'd0);
        flush = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("fl_idle_we", rd_we, 0);
        check("fl_idle_instret", instret, 15);

        // flush in WAIT coinciding with the response
        op(2'b01, 5'd15, 32'h0, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        check("fl_wait_busy", busy, 1);
        flush = 1'b1;
        mem_rsp_valid = 1'b1;
        tick();
        flush = 1'b0;
        mem_rsp_valid = 1'b0;
        check("fl_wait_we", rd_we, 0);
        check("fl_wait_ready", in_ready, 1);
        check("fl_wait_instret", instret, 15);
        tick();
        check("fl_wait_we2", rd_we, 0);

        // reset mid-WAIT drops the pending load
        op(2'b01, 5'd16, 32'h0, 3'b010, 2'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("rw_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_we", rd_we, 0);
        check("rw_addr", rd_addr, 0);
        check("rw_wdata", rd_wdata, 0);
        check("rw_instret", instret, 0);
        check("rw_busy0", busy, 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1111_1111;
        tick();
        mem_rsp_valid = 1'b0;
        check("rw_no_commit", rd_we, 0);
        check("rw_instret2", instret, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
